// File: rtl/dcache_mem_arbiter.sv
// Round-robin arbiter that moves dcache fill reads and eviction writes onto memory channels.
// Optional perf counters are enabled by defining DCACHE_MEM_ARBITER_PERF_EN.
module dcache_mem_arbiter #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 8,
  parameter int NUM_CHANNELS  = 4
) (
  input  logic                                     clk,
  input  logic                                     reset,
`ifdef DCACHE_MEM_ARBITER_PERF_EN
  output logic [31:0]                              perf_grant_count,
  output logic [31:0]                              perf_stall_count,
`endif
  input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                 consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                 consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]                  mem_read_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_read_address,
  input  logic [NUM_CHANNELS-1:0]                  mem_read_ready,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_read_data,
  output logic [NUM_CHANNELS-1:0]                  mem_write_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_write_address,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_write_data,
  input  logic [NUM_CHANNELS-1:0]                  mem_write_ready
);

  localparam int SLOT_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam int CNT_W  = $clog2(NUM_CHANNELS + 1);

  typedef logic [SLOT_W-1:0] slot_t;
  typedef enum logic [2:0] {
    IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING
  } state_t;

  state_t                   state [NUM_CHANNELS];
  slot_t                    slot  [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0] claim;
  slot_t                    rr_ptr;

  logic [NUM_CHANNELS-1:0]  grant_valid;
  logic [NUM_CHANNELS-1:0]  grant_write;
  slot_t                    grant_slot [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0] taken;
  logic [SLOT_W:0]          scan_sum;
  slot_t                    scan_idx;
  logic [SLOT_W:0]          rr_sum;
  slot_t                    next_rr;
  logic [CNT_W-1:0]         grant_count;

  // Channels resolve in ascending order; 'taken' carries each grant forward so a
  // slot picked by a lower channel is invisible to the higher ones.
  always_comb begin
    // NOTE: blocking assignments here model the ordered channel-by-channel scan;
    // every variable gets a default first so no latch is inferred.
    taken       = claim;
    grant_valid = '0;
    grant_write = '0;
    scan_sum    = '0;
    scan_idx    = '0;
    rr_sum      = '0;
    next_rr     = rr_ptr;
    grant_count = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) grant_slot[c] = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (state[c] == IDLE) begin
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
          scan_sum = {1'b0, rr_ptr} + (SLOT_W+1)'(k);
          if (scan_sum >= (SLOT_W+1)'(NUM_CONSUMERS))
            scan_sum = scan_sum - (SLOT_W+1)'(NUM_CONSUMERS);
          scan_idx = scan_sum[SLOT_W-1:0];
          if (!grant_valid[c] && !taken[scan_idx] &&
              (consumer_read_valid[scan_idx] || consumer_write_valid[scan_idx])) begin
            grant_valid[c]  = 1'b1;
            grant_write[c]  = consumer_write_valid[scan_idx];
            grant_slot[c]   = scan_idx;
            taken[scan_idx] = 1'b1;
            grant_count     = grant_count + CNT_W'(1);
            rr_sum          = {1'b0, scan_idx} + (SLOT_W+1)'(1);
            next_rr         = (rr_sum >= (SLOT_W+1)'(NUM_CONSUMERS)) ? '0 : rr_sum[SLOT_W-1:0];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the per-slot data registers are outputs that must read 0 in reset,
      // so they are cleared here rather than left as uninitialised storage.
      claim                <= '0;
      rr_ptr               <= '0;
      consumer_read_ready  <= '0;
      consumer_read_data   <= '0;
      consumer_write_ready <= '0;
      mem_read_valid       <= '0;
      mem_read_address     <= '0;
      mem_write_valid      <= '0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state[c] <= IDLE;
        slot[c]  <= '0;
      end
    end else begin
      if (grant_count != '0) rr_ptr <= next_rr;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        case (state[c])
          IDLE: if (grant_valid[c]) begin
            slot[c]              <= grant_slot[c];
            claim[grant_slot[c]] <= 1'b1;
            if (grant_write[c]) begin
              mem_write_valid[c]   <= 1'b1;
              mem_write_address[c] <= consumer_write_address[grant_slot[c]];
              mem_write_data[c]    <= consumer_write_data[grant_slot[c]];
              state[c]             <= WRITE_WAITING;
            end else begin
              mem_read_valid[c]    <= 1'b1;
              mem_read_address[c]  <= consumer_read_address[grant_slot[c]];
              state[c]             <= READ_WAITING;
            end
          end
          READ_WAITING: if (mem_read_ready[c]) begin
            mem_read_valid[c]            <= 1'b0;
            consumer_read_data[slot[c]]  <= mem_read_data[c];
            consumer_read_ready[slot[c]] <= 1'b1;
            state[c]                     <= READ_RELAYING;
          end
          WRITE_WAITING: if (mem_write_ready[c]) begin
            mem_write_valid[c]            <= 1'b0;
            consumer_write_ready[slot[c]] <= 1'b1;
            state[c]                      <= WRITE_RELAYING;
          end
          READ_RELAYING: if (!consumer_read_valid[slot[c]]) begin
            consumer_read_ready[slot[c]] <= 1'b0;
            claim[slot[c]]               <= 1'b0;
            state[c]                     <= IDLE;
          end
          WRITE_RELAYING: if (!consumer_write_valid[slot[c]]) begin
            consumer_write_ready[slot[c]] <= 1'b0;
            claim[slot[c]]                <= 1'b0;
            state[c]                      <= IDLE;
          end
          default: state[c] <= IDLE;
        endcase
      end
    end
  end

`ifdef DCACHE_MEM_ARBITER_PERF_EN
  logic [NUM_CONSUMERS-1:0] stalled;
  logic [32:0]              grant_sum;

  // A stalled slot is requesting, unclaimed, and lost arbitration this cycle.
  assign stalled   = (consumer_read_valid | consumer_write_valid) & ~taken;
  assign grant_sum = {1'b0, perf_grant_count} + 33'(grant_count);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_grant_count <= '0;
      perf_stall_count <= '0;
    end else begin
      perf_grant_count <= grant_sum[32] ? '1 : grant_sum[31:0];
      if (|stalled && perf_stall_count != '1)
        perf_stall_count <= perf_stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_mem_arbiter.sv
// Directed bench for dcache_mem_arbiter: reset, single read, write priority,
// contention, wrap-around, early valid drop and (when enabled) perf counters.
module tb_dcache_mem_arbiter;

  logic clk;
  logic reset;
  logic [7:0]      crv, crr, cwv, cwr;
  logic [7:0][7:0] cra, crd, cwa, cwd;
  logic [3:0]      mrv, mrr, mwv, mwr;
  logic [3:0][7:0] mra, mrd, mwa, mwd;

  int passed = 0;
  int total  = 0;

`ifdef DCACHE_MEM_ARBITER_PERF_EN
  logic [31:0]     dut_grants, dut_stalls;
  logic [31:0]     p_grants, p_stalls;
  logic [7:0]      p_crv, p_crr, p_cwr;
  logic [7:0][7:0] p_crd;
  logic [0:0]      p_mrv, p_mwv;
  logic [0:0][7:0] p_mra, p_mwa, p_mwd;
`endif

  dcache_mem_arbiter #(
    .ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(8), .NUM_CHANNELS(4)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
`ifdef DCACHE_MEM_ARBITER_PERF_EN
    .perf_grant_count       (dut_grants),
    .perf_stall_count       (dut_stalls),
`endif
    .consumer_read_valid    (crv),
    .consumer_read_address  (cra),
    .consumer_read_ready    (crr),
    .consumer_read_data     (crd),
    .consumer_write_valid   (cwv),
    .consumer_write_address (cwa),
    .consumer_write_data    (cwd),
    .consumer_write_ready   (cwr),
    .mem_read_valid         (mrv),
    .mem_read_address       (mra),
    .mem_read_ready         (mrr),
    .mem_read_data          (mrd),
    .mem_write_valid        (mwv),
    .mem_write_address      (mwa),
    .mem_write_data         (mwd),
    .mem_write_ready        (mwr)
  );

`ifdef DCACHE_MEM_ARBITER_PERF_EN
  // Single-channel instance with memory always ready, used for the counter schedule.
  dcache_mem_arbiter #(
    .ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(8), .NUM_CHANNELS(1)
  ) perf_dut (
    .clk                    (clk),
    .reset                  (reset),
    .perf_grant_count       (p_grants),
    .perf_stall_count       (p_stalls),
    .consumer_read_valid    (p_crv),
    .consumer_read_address  ('0),
    .consumer_read_ready    (p_crr),
    .consumer_read_data     (p_crd),
    .consumer_write_valid   (8'h00),
    .consumer_write_address ('0),
    .consumer_write_data    ('0),
    .consumer_write_ready   (p_cwr),
    .mem_read_valid         (p_mrv),
    .mem_read_address       (p_mra),
    .mem_read_ready         (1'b1),
    .mem_read_data          (8'h42),
    .mem_write_valid        (p_mwv),
    .mem_write_address      (p_mwa),
    .mem_write_data         (p_mwd),
    .mem_write_ready        (1'b1)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  // Advance one clock and settle 1ns past the edge before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    crv = '0; cra = '0; cwv = '0; cwa = '0; cwd = '0;
    mrr = '0; mrd = '0; mwr = '0;
`ifdef DCACHE_MEM_ARBITER_PERF_EN
    p_crv = '0;
`endif
    step(); step();
    check("reset_mem_read_valid",  64'(mrv), 64'h0);
    check("reset_mem_write_valid", 64'(mwv), 64'h0);
    check("reset_read_ready",      64'(crr), 64'h0);
    check("reset_write_ready",     64'(cwr), 64'h0);
    check("reset_read_data",       64'(crd), 64'h0);
    reset = 1'b1;
    step();

    // Single read: slot 3, address 0x5A, memory answers 0xC3 two cycles later.
    crv[3] = 1'b1; cra[3] = 8'h5A;
    step();
    check("single_mem_valid", 64'(mrv), 64'h1);
    check("single_mem_addr",  64'(mra[0]), 64'h5A);
    check("single_rr_ptr",    64'(dut.rr_ptr), 64'h4);
    step();
    check("single_mem_hold",  64'(mrv), 64'h1);
    mrr[0] = 1'b1; mrd[0] = 8'hC3;
    step();
    mrr = '0; mrd = '0;
    check("single_ready",     64'(crr), 64'h08);
    check("single_data",      64'(crd[3]), 64'hC3);
    check("single_mem_drop",  64'(mrv), 64'h0);
    step();
    check("single_ready_held", 64'(crr), 64'h08);
    check("single_data_held",  64'(crd[3]), 64'hC3);
    crv[3] = 1'b0;
    step();
    check("single_release", 64'(crr), 64'h0);

    // Memory ready with every channel idle must not produce a consumer ack.
    mrr[2] = 1'b1; mrd[2] = 8'h99;
    step();
    mrr = '0; mrd = '0;
    check("idle_ready_ignored", 64'(crr), 64'h0);

    // Write priority: slot 2 asks for write 0x10/0xEE and read 0x20 together.
    cwv[2] = 1'b1; cwa[2] = 8'h10; cwd[2] = 8'hEE;
    crv[2] = 1'b1; cra[2] = 8'h20;
    step();
    check("wp_mem_write_valid", 64'(mwv), 64'h1);
    check("wp_mem_write_addr",  64'(mwa[0]), 64'h10);
    check("wp_mem_write_data",  64'(mwd[0]), 64'hEE);
    check("wp_no_read_yet",     64'(mrv), 64'h0);
    mwr[0] = 1'b1;
    step();
    mwr = '0;
    check("wp_write_ready",     64'(cwr), 64'h04);
    check("wp_mem_write_drop",  64'(mwv), 64'h0);
    cwv[2] = 1'b0;
    step();
    check("wp_write_release",   64'(cwr), 64'h0);
    check("wp_no_regrant_release_cycle", 64'(mrv), 64'h0);
    step();
    check("wp_read_valid",      64'(mrv), 64'h1);
    check("wp_read_addr",       64'(mra[0]), 64'h20);
    check("wp_rr_ptr",          64'(dut.rr_ptr), 64'h3);
    mrr[0] = 1'b1; mrd[0] = 8'h77;
    step();
    mrr = '0; mrd = '0;
    check("wp_read_ready",      64'(crr), 64'h04);
    check("wp_read_data",       64'(crd[2]), 64'h77);
    crv[2] = 1'b0;
    step();
    check("wp_read_release",    64'(crr), 64'h0);

    // Asynchronous reset in the middle of READ_WAITING.
    crv[5] = 1'b1; cra[5] = 8'h33;
    step();
    check("arst_pre_valid", 64'(mrv), 64'h1);
    #2 reset = 1'b0;
    #1;
    check("arst_mem_read_valid",  64'(mrv), 64'h0);
    check("arst_mem_write_valid", 64'(mwv), 64'h0);
    check("arst_read_ready",      64'(crr), 64'h0);
    check("arst_write_ready",     64'(cwr), 64'h0);
    check("arst_rr_ptr",          64'(dut.rr_ptr), 64'h0);
    crv[5] = 1'b0;
    step();
    reset = 1'b1;
    step();

    // Contention: all 8 slots read at once with rr_ptr=0.
    crv = 8'hFF;
    for (int i = 0; i < 8; i++) cra[i] = 8'h80 + 8'(i);
    step();
    check("cont_valid_1",  64'(mrv), 64'hF);
    check("cont_addr_1",   64'(mra), 64'h83828180);
    check("cont_rr_ptr_1", 64'(dut.rr_ptr), 64'h4);
    mrr = 4'hF; mrd = 32'hD3D2D1D0;
    step();
    mrr = '0;
    check("cont_ready_1",  64'(crr), 64'h0F);
    check("cont_data_1",   64'(crd[3:0]), 64'hD3D2D1D0);
    check("cont_drop_1",   64'(mrv), 64'h0);
    crv[3:0] = 4'h0;
    step();
    check("cont_release_1",   64'(crr), 64'h0);
    check("cont_no_early_gnt", 64'(mrv), 64'h0);
    step();
    check("cont_valid_2",  64'(mrv), 64'hF);
    check("cont_addr_2",   64'(mra), 64'h87868584);
    check("cont_rr_ptr_2", 64'(dut.rr_ptr), 64'h0);
    mrr = 4'hF; mrd = 32'hE7E6E5E4;
    step();
    mrr = '0;
    check("cont_ready_2",  64'(crr), 64'hF0);
    check("cont_data_2",   64'(crd[7:4]), 64'hE7E6E5E4);
    crv = '0;
    step();
    check("cont_release_2", 64'(crr), 64'h0);
    step();
    check("cont_quiet",     64'(mrv), 64'h0);

    // Move rr_ptr to 6 with a single grant on slot 5.
    crv[5] = 1'b1; cra[5] = 8'h55;
    step();
    check("wrap_setup_rr", 64'(dut.rr_ptr), 64'h6);
    mrr[0] = 1'b1; mrd[0] = 8'h11;
    step();
    mrr = '0;
    crv[5] = 1'b0;
    step();

    // Wrap-around: slots 7 and 1 from rr_ptr=6; slot 1 drops valid while waiting.
    crv[7] = 1'b1; cra[7] = 8'hA7;
    crv[1] = 1'b1; cra[1] = 8'hA1;
    step();
    check("wrap_valid",   64'(mrv), 64'h3);
    check("wrap_ch0",     64'(mra[0]), 64'hA7);
    check("wrap_ch1",     64'(mra[1]), 64'hA1);
    check("wrap_rr_ptr",  64'(dut.rr_ptr), 64'h2);
    crv[1] = 1'b0;
    step();
    check("drop_mem_still_valid", 64'(mrv), 64'h3);
    mrr = 4'h3; mrd[0] = 8'hB7; mrd[1] = 8'hB1;
    step();
    mrr = '0;
    check("wrap_ready",   64'(crr), 64'h82);
    check("wrap_data7",   64'(crd[7]), 64'hB7);
    check("wrap_data1",   64'(crd[1]), 64'hB1);
    step();
    check("drop_one_cycle_ready", 64'(crr), 64'h80);
    crv[7] = 1'b0;
    step();
    check("wrap_release", 64'(crr), 64'h0);

`ifdef DCACHE_MEM_ARBITER_PERF_EN
    // Three slots on one always-ready channel; slot 0 never releases, so one
    // grant happens and slots 1 and 2 stall on every one of the 10 edges.
    check("perf_grant_start", 64'(p_grants), 64'h0);
    check("perf_stall_start", 64'(p_stalls), 64'h0);
    p_crv = 8'h07;
    for (int i = 0; i < 10; i++) step();
    check("perf_grants", 64'(p_grants), 64'd1);
    check("perf_stalls", 64'(p_stalls), 64'd10);
    p_crv = '0;
    reset = 1'b0;
    #1;
    check("perf_grant_reset", 64'(p_grants), 64'h0);
    check("perf_stall_reset", 64'(p_stalls), 64'h0);
    step();
    reset = 1'b1;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
